// File: rtl/pwm_sample_scheduler.sv
// pwm_sample_scheduler: feeds a PWM DAC with one duty sample per 2^W-cycle period.
// Two round-robin sources fill a one-entry holding register; the held sample
// is promoted to duty at each period boundary.
// Optional feature macro: PWM_SCHED_UNDERRUN_CNT_EN enables the saturating
// underrun counter; when undefined underrun_cnt is tied to zero.
module pwm_sample_scheduler #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         s0_valid,
    input  logic         s1_valid,
    input  logic [W-1:0] s0_data,
    input  logic [W-1:0] s1_data,
    output logic         s0_ready,
    output logic         s1_ready,
    output logic [W-1:0] duty,
    output logic         period_start,
    output logic         busy,
    output logic [7:0]   underrun_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t       state, state_nxt;
    logic [W-1:0] cnt;
    logic [W-1:0] hold_data;
    logic         hold_full;
    logic         last_s1;
    logic         period_end;
    logic         boundary;
    logic         stop_end;
    logic         accept_ok;
    logic         xfer;

    // A boundary only exists while running; the last STOP cycle is the
    // shutdown point instead and has its own side effects.
    assign period_end = (cnt == {W{1'b1}});
    assign boundary   = (state == RUN) && period_end;
    assign stop_end   = (state == STOP) && period_end;
    assign busy       = (state != IDLE);
    assign accept_ok  = (state != STOP) && (!hold_full || boundary);
    assign xfer       = s0_ready || s1_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and round-robin grant; readies are combinational from valids
    always_comb begin
        state_nxt = state;
        s0_ready  = 1'b0;
        s1_ready  = 1'b0;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN:     if (!en) state_nxt = STOP;
            STOP: begin
                if (period_end) state_nxt = IDLE;
                else if (en)    state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
        if (accept_ok) begin
            if (s0_valid && s1_valid) begin
                s0_ready = last_s1;
                s1_ready = !last_s1;
            end else begin
                s0_ready = s0_valid;
                s1_ready = s1_valid;
            end
        end
    end

    // Period counter: parked at zero in IDLE, free-running otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              cnt <= '0;
        else if (state == IDLE)  cnt <= '0;
        else                     cnt <= cnt + 1'b1;
    end

    // Holding register: a same-edge refill wins over the boundary drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (xfer) begin
            hold_data <= s0_ready ? s0_data : s1_data;
            hold_full <= 1'b1;
        end else if (boundary || stop_end) begin
            hold_full <= 1'b0;
        end
    end

    // Last-served pointer for tie-breaking; starts on source 1 so source 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     last_s1 <= 1'b1;
        else if (xfer)  last_s1 <= s1_ready;
    end

    // Duty update at boundaries; shutdown forces zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     duty <= '0;
        else if (stop_end)              duty <= '0;
        else if (boundary && hold_full) duty <= hold_data;
    end

    // period_start marks the first cycle the new duty is visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) period_start <= 1'b0;
        else        period_start <= boundary;
    end

`ifdef PWM_SCHED_UNDERRUN_CNT_EN
    logic [7:0] urun;

    // Saturating count of boundaries that found the holding register empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                      urun <= '0;
        else if (boundary && !hold_full && urun != 8'hFF) urun <= urun + 8'd1;
    end

    assign underrun_cnt = urun;
`else
    assign underrun_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pwm_sample_scheduler.sv
// Bench for pwm_sample_scheduler: behavioural queue model plus a scoreboard of
// expected duty values popped on each period_start pulse.
module tb_pwm_sample_scheduler;

    localparam int W    = 6;
    localparam int P    = 1 << W;
    localparam int MAXV = P - 1;

    typedef logic [W-1:0] samp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         s0_valid = 1'b0;
    logic         s1_valid = 1'b0;
    samp_t        s0_data = '0;
    samp_t        s1_data = '0;
    logic         s0_ready, s1_ready, period_start, busy;
    samp_t        duty;
    logic [7:0]   underrun_cnt;

    always #5 clk = ~clk;

    pwm_sample_scheduler #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .s0_valid(s0_valid), .s1_valid(s1_valid),
        .s0_data(s0_data), .s1_data(s1_data),
        .s0_ready(s0_ready), .s1_ready(s1_ready),
        .duty(duty), .period_start(period_start), .busy(busy),
        .underrun_cnt(underrun_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=idle 1=run 2=stop, phase = cycle within period,
    // pending = samples accepted but not yet shown on duty.
    int    mode = 0, phase = 0, last_src = 1, urun_m = 0;
    bit    ps_m = 0;
    samp_t duty_m = '0;
    samp_t pending[$];
    samp_t exp_q[$];

    int    nmode, nphase;
    bit    pend, bnd, open, g0, g1;

    function automatic int urun_exp();
`ifdef PWM_SCHED_UNDERRUN_CNT_EN
        return urun_m;
`else
        return 0;
`endif
    endfunction

    // Model step + per-cycle compare, evaluated mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (duty !== '0 || period_start !== 1'b0 || busy !== 1'b0 || underrun_cnt !== 8'd0) begin
                errors++;
                $display("FAIL reset_outputs duty=%0h ps=%0b busy=%0b urun=%0d required all 0",
                         duty, period_start, busy, underrun_cnt);
            end
            mode = 0; phase = 0; last_src = 1; urun_m = 0; ps_m = 0; duty_m = '0;
            pending.delete();
            exp_q.delete();
        end else begin
            pend = (phase == MAXV);
            bnd  = (mode == 1) && pend;
            open = (mode != 2) && (pending.size() == 0 || bnd);
            g0 = 0; g1 = 0;
            if (open) begin
                if (s0_valid && s1_valid) begin
                    g0 = (last_src == 1);
                    g1 = !g0;
                end else begin
                    g0 = s0_valid;
                    g1 = s1_valid;
                end
            end
            checks++;
            if ({s0_ready, s1_ready, busy, period_start} !== {g0, g1, (mode != 0), ps_m} ||
                duty !== duty_m || underrun_cnt !== 8'(urun_exp())) begin
                errors++;
                $display("FAIL cycle t=%0t rdy=%b%b busy=%b ps=%b duty=%0h urun=%0d required rdy=%b%b busy=%b ps=%b duty=%0h urun=%0d",
                         $time, s0_ready, s1_ready, busy, period_start, duty, underrun_cnt,
                         g0, g1, (mode != 0), ps_m, duty_m, urun_exp());
            end
            // effects of the coming edge
            ps_m = bnd;
            if (bnd) begin
                if (pending.size() != 0) duty_m = pending.pop_front();
                else if (urun_m < 255)   urun_m++;
                exp_q.push_back(duty_m);
            end
            if (mode == 2 && pend) begin
                pending.delete();
                duty_m = '0;
            end
            if (g0) begin pending.push_back(s0_data); last_src = 0; end
            if (g1) begin pending.push_back(s1_data); last_src = 1; end
            nphase = (mode == 0) ? 0 : (phase + 1) % P;
            case (mode)
                0:       nmode = en ? 1 : 0;
                1:       nmode = en ? 1 : 2;
                default: nmode = pend ? 0 : (en ? 1 : 2);
            endcase
            mode  = nmode;
            phase = nphase;
        end
    end

    // Scoreboard monitor: every period_start must match the next expected duty
    always @(negedge clk) begin
        if (rst_n && period_start) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected period_start duty=%0h required no pulse", duty);
            end else begin
                samp_t e;
                e = exp_q.pop_front();
                if (duty !== e) begin
                    errors++;
                    $display("FAIL sb_duty got=%0h required=%0h", duty, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) step();
    endtask

    // Advance until the model says the current cycle is RUN at counter k
    task automatic wait_phase(input int k);
        int t;
        t = 0;
        while (!(mode == 1 && phase == k)) begin
            step();
            t++;
            if (t > 4 * P) begin
                checks++;
                errors++;
                $display("FAIL wait_phase timeout k=%0d mode=%0d required run", k, mode);
                return;
            end
        end
    endtask

    initial begin
        run_cycles(3);
        rst_n = 1'b1;
        step();

        // preload in IDLE, then run: first period duty 0, then the preload
        s0_valid = 1; s0_data = 6'h20;
        step();
        s0_valid = 0; en = 1;
        run_cycles(2 * P + 4);

        // both sources held valid: alternate starting from source 0
        s0_valid = 1; s0_data = 6'h11;
        s1_valid = 1; s1_data = 6'h22;
        run_cycles(4 * P);
        s0_valid = 0; s1_valid = 0;

        // refill on the boundary edge itself
        wait_phase(5);
        s0_valid = 1; s0_data = 6'h0A;
        step();
        s0_valid = 0;
        wait_phase(MAXV);
        s1_valid = 1; s1_data = 6'h19;
        step();
        s1_valid = 0;
        run_cycles(2 * P);

        // underruns, then saturation
        run_cycles(3 * P);
        run_cycles(300 * P);

        // stop with a held sample: discarded at shutdown, readies low
        wait_phase(3);
        s0_valid = 1; s0_data = 6'h2A;
        step();
        s0_valid = 0;
        wait_phase(30);
        en = 0;
        s1_valid = 1; s1_data = 6'h33;
        run_cycles(P + 4);
        s1_valid = 0;

        // async reset mid-period
        en = 1;
        wait_phase(37);
        rst_n = 0;
        step();
        rst_n = 1;
        run_cycles(P + 5);

        // random traffic with occasional en drops
        for (int i = 0; i < 4000; i++) begin
            en       = ($urandom_range(0, 19) != 0);
            s0_valid = $urandom_range(0, 1) == 1;
            s1_valid = $urandom_range(0, 1) == 1;
            s0_data  = samp_t'($urandom);
            s1_data  = samp_t'($urandom);
            step();
        end

        en = 0; s0_valid = 0; s1_valid = 0;
        run_cycles(2 * P + 4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover count=%0d required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_sample_scheduler.md
PWM_SAMPLE_SCHEDULER -- requirements
Module: pwm_sample_scheduler

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning the duty and period-counter width; the PWM period is 2^W cycles.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all logic rising-edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port en, input, 1 bit: run request.
REQ-005 The block SHALL have ports s0_valid and s1_valid, input, 1 bit each: a sample is offered on source 0 / source 1.
REQ-006 The block SHALL have ports s0_data and s1_data, input, W bits each: the offered sample.
REQ-007 The block SHALL have ports s0_ready and s1_ready, output, 1 bit each: the offered sample is accepted this cycle.
REQ-008 The block SHALL have port duty, output, W bits: registered duty value feeding the PWM DAC.
REQ-009 The block SHALL have port period_start, output, 1 bit: a one-cycle pulse in the first cycle a new duty is valid.
REQ-010 The block SHALL have port busy, output, 1 bit: high when the state is RUN or STOP.
REQ-011 The block SHALL have port underrun_cnt, output, 8 bits: count of period boundaries with no sample held.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and STOP, with the following transitions.
- IDLE->RUN when en=1.
- RUN->STOP when en=0.
- STOP->RUN when en=1 at a non-boundary cycle.
- STOP->IDLE at a boundary.
REQ-013 The counter SHALL be W bits, held at 0 in IDLE, and increment by 1 each cycle in RUN and STOP, wrapping from 2^W-1 to 0.
REQ-014 A boundary SHALL be a cycle in RUN with counter == 2^W-1.
REQ-015 The block SHALL have a one-entry holding register: hold_data (W bits) and hold_full.
REQ-016 A source SHALL be granted only when hold_full=0, or at a boundary, and the state is IDLE or RUN; sx_ready equals the grant, combinational from the valids.
REQ-017 Arbitration SHALL be round-robin.
- Only one valid: that source wins.
- Both valid: the source not served last wins.
- The last-served pointer resets to source 1, so source 0 wins the first tie.
REQ-018 A transfer SHALL occur on the edge where sx_valid && sx_ready; hold_data <= sx_data and hold_full <= 1.
REQ-019 At a boundary with hold_full=1, the block SHALL set duty <= hold_data and clear hold_full, unless a same-edge transfer refills it.
REQ-020 At a boundary with hold_full=0, duty SHALL keep its previous value, and underrun_cnt SHALL increment, saturating at 255.
REQ-021 A sample accepted on the boundary edge itself SHALL NOT reach duty until the next boundary.
REQ-022 period_start SHALL be registered, high exactly in the cycle after each boundary, coincident with counter==0 and the updated duty.
REQ-023 In STOP the following SHALL hold.
- Both readies are low.
- The current period completes.
- At the boundary, duty <= 0, hold_full <= 0 (the held sample is discarded) and no underrun is counted.
REQ-024 In IDLE, duty SHALL be 0 and samples MAY be preloaded into the holding register.
REQ-025 After IDLE->RUN, the first period SHALL output duty 0; the preloaded sample appears after the first boundary.
REQ-026 No sample SHALL be lost or duplicated: each accepted sample is either output for exactly one period or discarded by STOP.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the following.
- state=IDLE, counter=0, duty=0, hold_full=0, hold_data=0.
- period_start=0, underrun_cnt=0, last-served pointer=source 1.
REQ-028 Deassertion of rst_n SHALL take effect on the next clk edge; reset mid-period abandons the period with no boundary side effects.

Configuration
REQ-029 The macro PWM_SCHED_UNDERRUN_CNT_EN SHALL control the underrun counter.
- Defined: underrun_cnt behaves per REQ-020.
- Undefined: the counter logic is omitted and underrun_cnt is tied to 0; all other behaviour is identical.

Verification
REQ-030 Reset, en=1, s0 sends 0x40 once, W=8 -> duty=0 for cycles 0..255; duty=0x40 from cycle 256 with period_start pulse; underrun_cnt=0 if preloaded before the first boundary, 1 otherwise.
REQ-031 s0 and s1 held valid with 0x11/0x22 -> s0 granted first, then alternating; duty sequence 0x11,0x22,0x11,... one per 256 cycles.
REQ-032 Hold full, s1 valid with 0x99 at the boundary cycle -> s1_ready=1 on that cycle; duty takes the old hold value; 0x99 is output one period later.
REQ-033 No samples for 3 boundaries after duty=0x80 -> duty stays 0x80; underrun_cnt=3 (0 with PWM_SCHED_UNDERRUN_CNT_EN undefined); saturation check: 300 empty boundaries -> 255.
REQ-034 en dropped at counter=100 with hold full -> readies low; at counter=255, duty=0, busy=0 next cycle, held sample discarded, no underrun counted.
REQ-035 rst_n pulsed low at counter=37 in RUN -> all outputs 0 immediately; after release with en=1, counting restarts from 0.
